// File: rtl/fp_addsub_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp_pkg
// Description : Shared types and constant helpers for the sequential
//               floating-point add/subtract engine.
//               - fp_state_e    : FSM state encoding
//               - fp_unpacked_t : sign/exponent/fraction view of a default
//                                 (binary32-shaped) word
//               - fp_inf_word / fp_qnan_word : canonical +Inf / qNaN bit
//                                 patterns for any exponent/mantissa width,
//                                 returned in a wide vector for the caller
//                                 to size-cast
// Revision    : 1.0  initial release
// ============================================================================
package fp_pkg;

    localparam int FP_EXP_W_DEF = 8;
    localparam int FP_MAN_W_DEF = 23;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ALIGN = 3'd1,
        ST_ADD   = 3'd2,
        ST_NORM  = 3'd3,
        ST_PACK  = 3'd4,
        ST_DONE  = 3'd5
    } fp_state_e;

    typedef struct packed {
        logic                    sign;
        logic [FP_EXP_W_DEF-1:0] exp;
        logic [FP_MAN_W_DEF-1:0] frac;
    } fp_unpacked_t;

    // +Inf: exponent all ones, fraction zero, sign zero.
    function automatic logic [127:0] fp_inf_word(input int exp_w, input int man_w);
        logic [127:0] v;
        v = ((128'd1 << exp_w) - 128'd1) << man_w;
        return v;
    endfunction

    // Canonical quiet NaN: +Inf pattern with the fraction MSB set.
    function automatic logic [127:0] fp_qnan_word(input int exp_w, input int man_w);
        return fp_inf_word(exp_w, man_w) | (128'd1 << (man_w - 1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_addsub_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : fp_addsub_seq_if
// Description : Byte-load / start-done handshake bundle of fp_addsub_seq.
//   load_en, load_sel, load_idx, load_data : byte write into operand A/B
//   clr                                    : zero both operands
//   start, op_sub                          : launch A+B (0) or A-B (1)
//   busy, done                             : operation in flight / 1-cycle done
//   result, flag_ovf, flag_unf, flag_inv   : packed result and status
//   state_o                                : one-hot {DONE,PACK,NORM,ADD,ALIGN}
//   master = front end driving loads/start, slave = the engine.
// Revision    : 1.0  initial release
// ============================================================================
interface fp_addsub_seq_if #(
    parameter int EXP_W  = 8,
    parameter int MAN_W  = 23,
    parameter int BYTE_W = 8
);
    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int NL    = W / BYTE_W;
    localparam int IDX_W = (NL > 1) ? $clog2(NL) : 1;

    logic              load_en;
    logic              load_sel;
    logic [IDX_W-1:0]  load_idx;
    logic [BYTE_W-1:0] load_data;
    logic              clr;
    logic              start;
    logic              op_sub;
    logic              busy;
    logic              done;
    logic [W-1:0]      result;
    logic              flag_ovf;
    logic              flag_unf;
    logic              flag_inv;
    logic [4:0]        state_o;

    modport master (
        output load_en, load_sel, load_idx, load_data, clr, start, op_sub,
        input  busy, done, result, flag_ovf, flag_unf, flag_inv, state_o
    );

    modport slave (
        input  load_en, load_sel, load_idx, load_data, clr, start, op_sub,
        output busy, done, result, flag_ovf, flag_unf, flag_inv, state_o
    );
endinterface
`default_nettype wire

// File: rtl/fp_addsub_seq_loader.sv
`default_nettype none
// ============================================================================
// Module      : fp_operand_loader
// Description : Two byte-addressable W-bit operand registers.
//   clk, reset          : clock, async active-high reset (clears operands)
//   busy                : engine running; loads and clr are ignored
//   load_en/sel/idx/data: replace one byte lane of A (sel=0) or B (sel=1)
//   clr                 : zero both operands, takes priority over load_en
//   op_a, op_b          : current operand values
// Revision    : 1.0  initial release
// ============================================================================
module fp_operand_loader #(
    parameter int W      = 32,
    parameter int BYTE_W = 8,
    parameter int IDX_W  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              busy,
    input  logic              load_en,
    input  logic              load_sel,
    input  logic [IDX_W-1:0]  load_idx,
    input  logic [BYTE_W-1:0] load_data,
    input  logic              clr,
    output logic [W-1:0]      op_a,
    output logic [W-1:0]      op_b
);
    localparam int NL = W / BYTE_W;

    logic [BYTE_W-1:0] r_a [NL];
    logic [BYTE_W-1:0] r_b [NL];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NL; i++) begin
                r_a[i] <= '0;
                r_b[i] <= '0;
            end
        end else if (!busy) begin
            if (clr) begin
                for (int i = 0; i < NL; i++) begin
                    r_a[i] <= '0;
                    r_b[i] <= '0;
                end
            end else if (load_en) begin
                for (int i = 0; i < NL; i++) begin
                    if (load_idx == IDX_W'(i)) begin
                        if (load_sel) r_b[i] <= load_data;
                        else          r_a[i] <= load_data;
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NL; g++) begin : g_lane
        assign op_a[g*BYTE_W +: BYTE_W] = r_a[g];
        assign op_b[g*BYTE_W +: BYTE_W] = r_b[g];
    end

endmodule
`default_nettype wire

// File: rtl/fp_addsub_seq.sv
`default_nettype none
// ============================================================================
// Module      : fp_addsub_seq
// Description : Multi-cycle floating-point add/subtract engine.
//   clk   : system clock, rising edge
//   reset : asynchronous active-high reset, aborts any operation
//   bus   : fp_addsub_seq_if.slave (byte loads, start/busy/done, result,
//           ovf/unf/inv flags, one-hot state)
//   Flow: IDLE -> ALIGN -> ADD -> NORM (1..n) -> PACK -> DONE -> IDLE.
//   Denormal inputs are read as zero; rounding is toward zero.
// Revision    : 1.0  initial release
// ============================================================================
module fp_addsub_seq
    import fp_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int MAN_W  = 23,
    parameter int BYTE_W = 8,
    parameter int GRD_W  = 3
) (
    input  logic           clk,
    input  logic           reset,
    fp_addsub_seq_if.slave bus
);
    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int NL    = W / BYTE_W;
    localparam int IDX_W = (NL > 1) ? $clog2(NL) : 1;
    localparam int SIG_W = MAN_W + 1;          // hidden one + fraction
    localparam int EXT_W = SIG_W + GRD_W;      // significand with guard bits
    localparam int SUM_W = EXT_W + 1;          // plus carry

    localparam logic [W-1:0]     C_QNAN     = W'(fp_qnan_word(EXP_W, MAN_W));
    localparam logic [W-1:0]     C_PINF     = W'(fp_inf_word(EXP_W, MAN_W));
    localparam logic [EXP_W-1:0] C_EXP_ONES = '1;

    localparam logic [2:0] S_IDLE  = ST_IDLE;
    localparam logic [2:0] S_ALIGN = ST_ALIGN;
    localparam logic [2:0] S_ADD   = ST_ADD;
    localparam logic [2:0] S_NORM  = ST_NORM;
    localparam logic [2:0] S_PACK  = ST_PACK;
    localparam logic [2:0] S_DONE  = ST_DONE;

    logic [2:0]       r_state;
    logic [W-1:0]     r_opa, r_opb;
    logic             r_spec, r_spec_inv, r_unf;
    logic [W-1:0]     r_spec_word;
    logic             r_sx, r_sy, r_sign;
    logic [EXP_W-1:0] r_exp;
    logic [EXT_W-1:0] r_mx, r_my;
    logic [SUM_W-1:0] r_sum;
    logic [W-1:0]     r_result;
    logic             r_ovf_q, r_unf_q, r_inv_q;

    logic             w_busy;
    logic [W-1:0]     w_op_a, w_op_b;

    assign w_busy = (r_state != S_IDLE);

    fp_operand_loader #(
        .W      (W),
        .BYTE_W (BYTE_W),
        .IDX_W  (IDX_W)
    ) u_loader (
        .clk       (clk),
        .reset     (reset),
        .busy      (w_busy),
        .load_en   (bus.load_en),
        .load_sel  (bus.load_sel),
        .load_idx  (bus.load_idx),
        .load_data (bus.load_data),
        .clr       (bus.clr),
        .op_a      (w_op_a),
        .op_b      (w_op_b)
    );

    // ---------------- ALIGN datapath (from snapshotted operands) ----------
    logic                   w_sa, w_sb;
    logic [EXP_W-1:0]       w_ea, w_eb;
    logic [MAN_W-1:0]       w_fa, w_fb;
    logic                   w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
    logic [EXP_W+MAN_W-1:0] w_mag_a, w_mag_b;
    logic                   w_a_ge_b, w_special, w_spec_inv;
    logic [W-1:0]           w_spec_word;
    logic [SIG_W-1:0]       w_sig_a, w_sig_b;
    logic [EXP_W-1:0]       w_ex, w_ey, w_shift;
    logic [EXT_W-1:0]       w_extx, w_exty, w_exty_sh;
    logic                   w_sx, w_sy;
    logic [SUM_W-1:0]       w_sum;

    assign {w_sa, w_ea, w_fa} = r_opa;
    assign {w_sb, w_eb, w_fb} = r_opb;

    assign w_a_nan  = (w_ea == C_EXP_ONES) && (w_fa != '0);
    assign w_b_nan  = (w_eb == C_EXP_ONES) && (w_fb != '0);
    assign w_a_inf  = (w_ea == C_EXP_ONES) && (w_fa == '0);
    assign w_b_inf  = (w_eb == C_EXP_ONES) && (w_fb == '0);
    assign w_a_zero = (w_ea == '0);
    assign w_b_zero = (w_eb == '0);

    // Magnitude compare with denormals flushed so they never win over zero.
    assign w_mag_a  = w_a_zero ? '0 : {w_ea, w_fa};
    assign w_mag_b  = w_b_zero ? '0 : {w_eb, w_fb};
    assign w_a_ge_b = (w_mag_a >= w_mag_b);

    assign w_sig_a  = w_a_zero ? '0 : {1'b1, w_fa};
    assign w_sig_b  = w_b_zero ? '0 : {1'b1, w_fb};

    assign w_sx     = w_a_ge_b ? w_sa : w_sb;
    assign w_sy     = w_a_ge_b ? w_sb : w_sa;
    assign w_ex     = w_a_ge_b ? w_ea : w_eb;
    assign w_ey     = w_a_ge_b ? w_eb : w_ea;
    assign w_extx   = EXT_W'(w_a_ge_b ? w_sig_a : w_sig_b) << GRD_W;
    assign w_exty   = EXT_W'(w_a_ge_b ? w_sig_b : w_sig_a) << GRD_W;
    assign w_shift  = w_ex - w_ey;
    assign w_exty_sh = (int'(w_shift) >= EXT_W) ? '0 : (w_exty >> w_shift);

    assign w_special = w_a_nan | w_b_nan | w_a_inf | w_b_inf;

    always_comb begin
        w_spec_word = C_QNAN;
        w_spec_inv  = 1'b1;
        if (w_a_nan || w_b_nan) begin
            w_spec_word = C_QNAN;
            w_spec_inv  = 1'b1;
        end else if (w_a_inf && w_b_inf) begin
            // B already carries the effective sign, so differing signs mean Inf-Inf.
            if (w_sa == w_sb) begin
                w_spec_word = {w_sa, C_PINF[W-2:0]};
                w_spec_inv  = 1'b0;
            end
        end else if (w_a_inf) begin
            w_spec_word = {w_sa, C_PINF[W-2:0]};
            w_spec_inv  = 1'b0;
        end else if (w_b_inf) begin
            w_spec_word = {w_sb, C_PINF[W-2:0]};
            w_spec_inv  = 1'b0;
        end
    end

    // X is the larger magnitude, so the difference never goes negative.
    assign w_sum = (r_sx == r_sy) ? ({1'b0, r_mx} + {1'b0, r_my})
                                  : ({1'b0, r_mx} - {1'b0, r_my});

    // ---------------- FSM and registered datapath -------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_opa       <= '0;
            r_opb       <= '0;
            r_spec      <= 1'b0;
            r_spec_inv  <= 1'b0;
            r_spec_word <= '0;
            r_unf       <= 1'b0;
            r_sx        <= 1'b0;
            r_sy        <= 1'b0;
            r_sign      <= 1'b0;
            r_exp       <= '0;
            r_mx        <= '0;
            r_my        <= '0;
            r_sum       <= '0;
            r_result    <= '0;
            r_ovf_q     <= 1'b0;
            r_unf_q     <= 1'b0;
            r_inv_q     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_opa   <= w_op_a;
                        r_opb   <= {w_op_b[W-1] ^ bus.op_sub, w_op_b[W-2:0]};
                        r_unf   <= 1'b0;
                        r_state <= S_ALIGN;
                    end
                end
                S_ALIGN: begin
                    r_spec      <= w_special;
                    r_spec_word <= w_spec_word;
                    r_spec_inv  <= w_spec_inv;
                    r_sx        <= w_sx;
                    r_sy        <= w_sy;
                    r_exp       <= w_ex;
                    r_mx        <= w_extx;
                    r_my        <= w_exty_sh;
                    r_state     <= w_special ? S_PACK : S_ADD;
                end
                S_ADD: begin
                    r_sum   <= w_sum;
                    r_sign  <= (w_sum == '0) ? 1'b0 : r_sx;
                    r_state <= S_NORM;
                end
                S_NORM: begin
                    if (r_sum[SUM_W-1]) begin
                        r_sum   <= r_sum >> 1;
                        r_exp   <= r_exp + EXP_W'(1);
                        r_state <= S_PACK;
                    end else if (r_sum[EXT_W-1] || (r_sum == '0)) begin
                        r_state <= S_PACK;
                    end else if (r_exp <= EXP_W'(1)) begin
                        // Next left shift would leave the normal range: flush.
                        r_sum   <= '0;
                        r_unf   <= 1'b1;
                        r_state <= S_PACK;
                    end else begin
                        r_sum <= r_sum << 1;
                        r_exp <= r_exp - EXP_W'(1);
                    end
                end
                S_PACK: begin
                    r_ovf_q <= 1'b0;
                    r_unf_q <= 1'b0;
                    r_inv_q <= 1'b0;
                    if (r_spec) begin
                        r_result <= r_spec_word;
                        r_inv_q  <= r_spec_inv;
                    end else if (!r_sum[EXT_W-1]) begin
                        r_result <= {r_sign, {(W-1){1'b0}}};
                        r_unf_q  <= r_unf;
                    end else if (r_exp == C_EXP_ONES) begin
                        r_result <= {r_sign, C_PINF[W-2:0]};
                        r_ovf_q  <= 1'b1;
                    end else begin
                        // Guard bits dropped: round toward zero.
                        r_result <= {r_sign, r_exp, r_sum[EXT_W-2:GRD_W]};
                    end
                    r_state <= S_DONE;
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // ---------------- outputs ---------------------------------------------
    always_comb begin
        bus.state_o = 5'b00000;
        case (r_state)
            S_ALIGN: bus.state_o = 5'b00001;
            S_ADD:   bus.state_o = 5'b00010;
            S_NORM:  bus.state_o = 5'b00100;
            S_PACK:  bus.state_o = 5'b01000;
            S_DONE:  bus.state_o = 5'b10000;
            default: bus.state_o = 5'b00000;
        endcase
    end

    assign bus.busy     = w_busy;
    assign bus.done     = (r_state == S_DONE);
    assign bus.result   = r_result;
    assign bus.flag_ovf = r_ovf_q;
    assign bus.flag_unf = r_unf_q;
    assign bus.flag_inv = r_inv_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_addsub_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_addsub_seq
// Description : Directed self-checking bench for fp_addsub_seq (binary32
//               configuration) with hand-computed expected results.
// Revision    : 1.0  initial release
// ============================================================================
module tb_fp_addsub_seq;

    logic clk;
    logic reset;

    fp_addsub_seq_if #(.EXP_W(8), .MAN_W(23), .BYTE_W(8)) bus ();

    fp_addsub_seq #(
        .EXP_W  (8),
        .MAN_W  (23),
        .BYTE_W (8),
        .GRD_W  (3)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [4:0] st_seq [0:63];
    logic       busy_drop;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic load_word(input logic sel, input logic [31:0] word);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.load_en   = 1'b1;
            bus.load_sel  = sel;
            bus.load_idx  = 2'(i);
            bus.load_data = word[8*i +: 8];
        end
        @(negedge clk);
        bus.load_en = 1'b0;
    endtask

    // Returns just after the accepting edge (edge 0).
    task automatic do_start(input logic sub);
        @(negedge clk);
        bus.op_sub = sub;
        bus.start  = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        st_seq[0] = bus.state_o;
    endtask

    // lat = number of rising edges after the last observed point until done.
    task automatic wait_done(input string tag, output int lat);
        lat       = 0;
        busy_drop = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            if (k < 64) st_seq[k] = bus.state_o;
            if (bus.done) begin
                lat = k;
                break;
            end
            if (!bus.busy) busy_drop = 1'b1;
        end
        if (lat == 0) check_val({tag, "_timeout"}, 64'(bus.done), 64'd1);
    endtask

    task automatic exec_check(input string tag, input logic sub, input logic [31:0] exp_res,
                              input logic [2:0] exp_flg, input int exp_lat);
        int lat;
        do_start(sub);
        wait_done(tag, lat);
        check_val({tag, "_res"}, 64'(bus.result), 64'(exp_res));
        check_val({tag, "_flags"}, 64'({bus.flag_ovf, bus.flag_unf, bus.flag_inv}), 64'(exp_flg));
        check_val({tag, "_busy_held"}, 64'(busy_drop), 64'd0);
        if (exp_lat > 0) check_val({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        @(posedge clk);
        #1;
        check_val({tag, "_done_pulse"}, 64'({bus.done, bus.busy}), 64'd0);
        check_val({tag, "_res_hold"}, 64'(bus.result), 64'(exp_res));
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sub, input logic [31:0] exp_res,
                          input logic [2:0] exp_flg, input int exp_lat);
        load_word(1'b0, a);
        load_word(1'b1, b);
        exec_check(tag, sub, exp_res, exp_flg, exp_lat);
    endtask

    initial begin
        int   lat;
        logic seen_done;

        reset         = 1'b1;
        bus.load_en   = 1'b0;
        bus.load_sel  = 1'b0;
        bus.load_idx  = '0;
        bus.load_data = '0;
        bus.clr       = 1'b0;
        bus.start     = 1'b0;
        bus.op_sub    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_result", 64'(bus.result), 64'd0);
        check_val("rst_busy_done", 64'({bus.busy, bus.done}), 64'd0);
        check_val("rst_state", 64'(bus.state_o), 64'd0);
        check_val("rst_flags", 64'({bus.flag_ovf, bus.flag_unf, bus.flag_inv}), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // 1.5 + 2.25 = 3.75, carry-free single NORM cycle
        run_op("add_basic", 32'h3FC00000, 32'h40100000, 1'b0, 32'h40700000, 3'b000, 4);
        check_val("walk0", 64'(st_seq[0]), 64'b00001);
        check_val("walk1", 64'(st_seq[1]), 64'b00010);
        check_val("walk2", 64'(st_seq[2]), 64'b00100);
        check_val("walk3", 64'(st_seq[3]), 64'b01000);
        check_val("walk4", 64'(st_seq[4]), 64'b10000);

        // 1.0 - 0.99999994 = 2^-24: 24 left shifts
        run_op("sub_cancel", 32'h3F800000, 32'h3F7FFFFF, 1'b1, 32'h33800000, 3'b000, 28);

        // overflow, Inf-Inf, exact zero, denormal operand
        run_op("ovf", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b100, 4);
        run_op("inf_sub_inf", 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b001, -1);
        run_op("exact_zero", 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000, 4);
        run_op("denorm", 32'h00400000, 32'hC0000000, 1'b0, 32'hC0000000, 3'b000, 4);

        // loads/clr/start while busy must be ignored
        load_word(1'b0, 32'h3F800000);
        load_word(1'b1, 32'h3F7FFFFF);
        do_start(1'b1);
        repeat (2) @(negedge clk);
        bus.start     = 1'b1;
        bus.op_sub    = 1'b0;
        bus.load_en   = 1'b1;
        bus.load_sel  = 1'b0;
        bus.load_idx  = 2'd3;
        bus.load_data = 8'h12;
        bus.clr       = 1'b1;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.load_en = 1'b0;
        bus.clr     = 1'b0;
        wait_done("busy_ign", lat);
        check_val("busy_ign_res", 64'(bus.result), 64'h33800000);
        @(posedge clk);
        exec_check("busy_ign_rerun", 1'b1, 32'h33800000, 3'b000, 28);

        // reset in the 5th NORM cycle aborts the operation
        do_start(1'b1);
        repeat (6) @(posedge clk);
        #1;
        check_val("abort_in_norm", 64'(bus.state_o), 64'b00100);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_val("abort_result", 64'(bus.result), 64'd0);
        check_val("abort_state", 64'({bus.busy, bus.done, bus.state_o}), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        seen_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) seen_done = 1'b1;
        end
        check_val("abort_no_done", 64'(seen_done), 64'd0);
        // operands were cleared by reset: 0 - 0 = +0
        exec_check("post_rst_zero_ops", 1'b1, 32'h00000000, 3'b000, 4);
        run_op("post_rst_add", 32'h3FC00000, 32'h40100000, 1'b0, 32'h40700000, 3'b000, 4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
